msu_sq_ctrl: RTL

Iteration sequencer for the MSU modular-squaring loop. It loads the initial value into the loop register, then commits exactly N squarings through the squarer and reduction pipeline, one commit every SqLatency cycles. It tracks completed iterations, supports abort, and signals completion to the host-side interface. The block sits beside the squarer/reduction datapath and drives only its mux-select and capture enables; it never touches data.

---
 rtl/msu_pkg.sv | 15 +
 rtl/msu_iter_counter.sv | 43 ++++
 rtl/msu_sq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/msu_pkg.sv
// Shared constants and types for the MSU squaring loop control.
// SqLatency here is the one value both the sequencer and the datapath derive from.
package msu_pkg;

  localparam int SqLatency   = 4;
  localparam int MsuIterBits = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } msu_sq_state_e;

endpackage

// File: rtl/msu_iter_counter.sv
// Remaining-iterations down-counter paired with a committed-iterations up-counter.
// term_o reports that no iterations remain after the most recent step.
module msu_iter_counter #(
  parameter int IterBits = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [IterBits-1:0] load_val_i,
  input  logic                step_i,
  output logic [IterBits-1:0] iter_count_o,
  output logic                term_o
);

  logic [IterBits-1:0] rem_q, rem_d;
  logic [IterBits-1:0] cnt_q, cnt_d;

  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = load_val_i;
      cnt_d = '0;
    end else if (step_i) begin
      rem_d = rem_q - IterBits'(1);
      cnt_d = cnt_q + IterBits'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign iter_count_o = cnt_q;
  assign term_o       = (rem_q == '0);

endmodule

// File: rtl/msu_sq_ctrl.sv
// Iteration sequencer for the MSU modular-squaring loop; drives mux select and capture only.
// Optional checkpoint pulse compiled in with MSU_SQ_CTRL_CKPT_EN.
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | capture initial value into loop register
// RUN   | phase counts 0..SqLatency-1, commit on last phase
// DONE  | one-cycle completion pulse
module msu_sq_ctrl #(
  parameter int IterBits  = msu_pkg::MsuIterBits,
  parameter int SqLatency = msu_pkg::SqLatency,
  parameter int CkptShift = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [IterBits-1:0] iters_i,
  input  logic                abort_i,
  output logic                sel_init_o,
  output logic                capture_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic [IterBits-1:0] iter_count_o,
  output logic                ckpt_o
);
  import msu_pkg::*;

  localparam int PhW = (SqLatency > 1) ? $clog2(SqLatency) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(SqLatency - 1);

  if (SqLatency < 2 || CkptShift < 1) begin : g_param_check
    $error("msu_sq_ctrl: SqLatency must be >= 2 and CkptShift >= 1");
  end

  msu_sq_state_e  state_q, state_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic           abort_hit, abort_pend_q;
  logic           cnt_load, cnt_step, cnt_term;
  logic           sel_init_q, sel_init_d, capture_q, capture_d;
  logic           busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  assign abort_hit = abort_i && (state_q == ST_LOAD || state_q == ST_RUN);
  assign cnt_load  = (state_q == ST_IDLE) && start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      abort_pend_q <= abort_hit;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (iters_i == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (phase_q == PhLast && cnt_term) begin
          state_d = ST_DONE;
        end else begin
          phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land registered in that state's cycle.
  always_comb begin
    sel_init_d = (state_d == ST_LOAD);
    cnt_step   = (state_d == ST_RUN) && (phase_d == PhLast);
    capture_d  = sel_init_d || cnt_step;
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
    aborted_d  = abort_pend_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_init_q <= 1'b0;
      capture_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      sel_init_q <= sel_init_d;
      capture_q  <= capture_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  msu_iter_counter #(.IterBits(IterBits)) u_iter_counter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (cnt_load),
    .load_val_i   (iters_i),
    .step_i       (cnt_step),
    .iter_count_o (iter_count_o),
    .term_o       (cnt_term)
  );

`ifdef MSU_SQ_CTRL_CKPT_EN
  logic [IterBits-1:0] cnt_next;
  logic                ckpt_q, ckpt_d;

  assign cnt_next = iter_count_o + IterBits'(1);
  assign ckpt_d   = cnt_step && (cnt_next[CkptShift-1:0] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ckpt_q <= 1'b0;
    else         ckpt_q <= ckpt_d;
  end

  assign ckpt_o = ckpt_q;
`else
  assign ckpt_o = 1'b0;
`endif

  assign sel_init_o = sel_init_q;
  assign capture_o  = capture_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;

endmodule
